// File: rtl/logic_gates_bank.sv
// ----------------------------------------------------------------------------
// logic_gates_bank
//   Bit-sliced bank of two-input logic gates with a registered result.
//   Bit i of y is gate(a[i], b[i]), where the gate is chosen by i mod 5:
//     0: AND   1: OR   2: NAND   3: NOR   4: XOR
//   The map repeats for WIDTH > 5 and is truncated for WIDTH < 5.
//   Bits are fully independent; X/Z on inputs propagate through the
//   operators unchanged.
//
// Ports
//   clk        in   1      system clock, rising-edge active
//   rst_n      in   1      asynchronous active-low reset
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   in_valid   in   1      a/b qualified this cycle
//   y          out  WIDTH  registered gate results (held when in_valid=0)
//   out_valid  out  1      y was captured on the previous rising edge
// ----------------------------------------------------------------------------
module logic_gates_bank #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic             out_valid
);

    // Applies the repeating five-gate map across every bit position.
    function automatic logic [WIDTH-1:0] gate_map(
        input logic [WIDTH-1:0] op_a,
        input logic [WIDTH-1:0] op_b
    );
        logic [WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (i % 32'sd5)
                32'sd0:  res[i] = op_a[i] & op_b[i];
                32'sd1:  res[i] = op_a[i] | op_b[i];
                32'sd2:  res[i] = ~(op_a[i] & op_b[i]);
                32'sd3:  res[i] = ~(op_a[i] | op_b[i]);
                32'sd4:  res[i] = op_a[i] ^ op_b[i];
                default: res[i] = 1'b0;
            endcase
        end
        return res;
    endfunction

    logic [WIDTH-1:0] gate_s;
    logic [WIDTH-1:0] y_r;
    logic             out_valid_r;

    // Combinational gate evaluation of the current operands.
    always_comb begin
        gate_s = gate_map(a, b);
    end

    // Result register: capture on valid, hold otherwise; valid flag follows
    // in_valid with one cycle of latency. Reset discards any in-flight sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r         <= '0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                y_r <= gate_s;
            end else begin
                y_r <= y_r;
            end
        end
    end

    assign y         = y_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_logic_gates_bank.sv
// ----------------------------------------------------------------------------
// tb_logic_gates_bank
//   Self-checking bench for logic_gates_bank. Directed vectors come from a
//   table of {a, b, expected y}; random vectors use an independent
//   truth-table model. Expected results are queued when stimulus is driven
//   and popped when the DUT raises out_valid. A second instance with
//   WIDTH=7 covers the wrap-around of the gate map.
// ----------------------------------------------------------------------------
module tb_logic_gates_bank;

    logic       clk;
    logic       rst_n;
    logic [4:0] a;
    logic [4:0] b;
    logic       in_valid;
    logic [4:0] y;
    logic       out_valid;

    logic [6:0] a7;
    logic [6:0] b7;
    logic [6:0] y7;
    logic       out_valid7;

    int compared   = 0;
    int mismatched = 0;

    logic [4:0] exp_q  [$];
    logic [6:0] exp7_q [$];

    typedef struct {
        logic [4:0] va;
        logic [4:0] vb;
        logic [4:0] vy;
    } vec_t;

    vec_t vecs [4];

    logic_gates_bank #(.WIDTH(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .y         (y),
        .out_valid (out_valid)
    );

    logic_gates_bank #(.WIDTH(7)) dut7 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a7),
        .b         (b7),
        .in_valid  (in_valid),
        .y         (y7),
        .out_valid (out_valid7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-gate truth tables indexed by {a,b}.
    // Nibble k holds gate k: AND=1000, OR=1110, NAND=0111, NOR=0001, XOR=0110.
    function automatic logic [15:0] model(input logic [15:0] av,
                                          input logic [15:0] bv,
                                          input int w);
        logic [19:0] tts;
        logic [15:0] r;
        int k;
        tts = {4'b0110, 4'b0001, 4'b0111, 4'b1110, 4'b1000};
        r = 16'h0000;
        for (int i = 0; i < w; i++) begin
            k = i % 5;
            r[i] = tts[k * 4 + int'({av[i], bv[i]})];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic pop_chk(input string name);
        chk({name, "_valid"}, {15'd0, out_valid}, 16'h0001);
        if (exp_q.size() == 0) begin
            chk({name, "_queue_empty"}, 16'h0001, 16'h0000);
        end else begin
            chk(name, {11'd0, y}, {11'd0, exp_q.pop_front()});
        end
    endtask

    initial begin
        vecs[0] = '{5'b00000, 5'b00000, 5'b01100};
        vecs[1] = '{5'b11111, 5'b11111, 5'b00011};
        vecs[2] = '{5'b11111, 5'b00000, 5'b10110};
        vecs[3] = '{5'b10110, 5'b01100, 5'b10010};

        // Reset asserted with active-looking inputs: outputs clear with no edge.
        rst_n    = 1'b0;
        a        = 5'h1F;
        b        = 5'h1F;
        a7       = 7'd0;
        b7       = 7'd0;
        in_valid = 1'b1;
        #2;
        chk("reset_y", {11'd0, y}, 16'h0000);
        chk("reset_valid", {15'd0, out_valid}, 16'h0000);
        @(posedge clk); #1;
        chk("reset_y_edge", {11'd0, y}, 16'h0000);

        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Directed table, back-to-back valid edges.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a        = vecs[i].va;
            b        = vecs[i].vb;
            in_valid = 1'b1;
            exp_q.push_back(vecs[i].vy);
            @(posedge clk); #1;
            pop_chk($sformatf("vec%0d", i));
        end

        // Hold: no valid, random operands, y must keep 10010.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a        = 5'($urandom);
            b        = 5'($urandom);
            @(posedge clk); #1;
            chk("hold_y", {11'd0, y}, 16'h0012);
            chk("hold_valid", {15'd0, out_valid}, 16'h0000);
        end

        // Async reset mid-stream: in-flight sample is discarded.
        @(negedge clk);
        a        = 5'h1F;
        b        = 5'h1F;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_y", {11'd0, y}, 16'h0000);
        chk("midrst_valid", {15'd0, out_valid}, 16'h0000);
        @(posedge clk); #1;
        chk("midrst_y_edge", {11'd0, y}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        a     = 5'b10110;
        b     = 5'b01100;
        exp_q.push_back(5'b10010);
        @(posedge clk); #1;
        pop_chk("after_rst");

        // Random pairs on both instances, checked against the model.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a        = 5'($urandom);
            b        = 5'($urandom);
            a7       = 7'($urandom);
            b7       = 7'($urandom);
            in_valid = 1'b1;
            exp_q.push_back(5'(model({11'd0, a}, {11'd0, b}, 5)));
            exp7_q.push_back(7'(model({9'd0, a7}, {9'd0, b7}, 7)));
            @(posedge clk); #1;
            pop_chk($sformatf("rand%0d", i));
            chk("w7_valid", {15'd0, out_valid7}, 16'h0001);
            if (exp7_q.size() == 0) begin
                chk("w7_queue_empty", 16'h0001, 16'h0000);
            end else begin
                chk($sformatf("w7_rand%0d", i), {9'd0, y7},
                    {9'd0, exp7_q.pop_front()});
            end
        end

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("end_valid", {15'd0, out_valid}, 16'h0000);
        chk("end_queue", 16'(exp_q.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
